// File: rtl/avr_fetch_unit_if.sv
// Fetch-stage bundle: next-PC control and program-memory address/data and the decoded opcode.
// slave = fetch unit, master = control unit / program memory side.
interface avr_fetch_unit_if #(
    parameter int PC_W = 16
);
    logic [2:0]      pc_src;
    logic [PC_W-1:0] jmp;
    logic [15:0]     prog_data;
    logic [PC_W-1:0] prog_addr;
    logic [15:0]     cur_instr;

    modport master (
        output pc_src,
        output jmp,
        output prog_data,
        input  prog_addr,
        input  cur_instr
    );

    modport slave (
        input  pc_src,
        input  jmp,
        input  prog_data,
        output prog_addr,
        output cur_instr
    );
endinterface

// File: rtl/avr_fetch_unit.sv
// AVR fetch stage: owns the PC, addresses program memory, registers the opcode for decode.
// Latency: one cycle from prog_addr to cur_instr; PC wraps to PMEM_AW bits when AVR_FETCH_PMEM_WRAP_EN is defined.
// Backpressure: none; STALL from pc_src holds PC and cur_instr in place.
module avr_fetch_unit #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RST_VEC  = '0,
    parameter logic [15:0]     NOP_WORD = 16'h0000,
    parameter int              PMEM_AW  = 9
) (
    input  logic              CLK,
    input  logic              RST,
    avr_fetch_unit_if.slave   bus
);

    typedef enum logic [2:0] {
        SRC_SEQ   = 3'b000,
        SRC_RSV1  = 3'b001,
        SRC_STALL = 3'b010,
        SRC_SKIP  = 3'b011,
        SRC_JMP   = 3'b100,
        SRC_RJMP  = 3'b101,
        SRC_RVEC  = 3'b110,
        SRC_RSV7  = 3'b111
    } pc_src_e;

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);
    localparam logic [PC_W-1:0] PC_TWO = PC_W'(2);

`ifdef AVR_FETCH_PMEM_WRAP_EN
    localparam logic [PC_W-1:0] PC_MASK = {{(PC_W-PMEM_AW){1'b0}}, {PMEM_AW{1'b1}}};
`else
    localparam logic [PC_W-1:0] PC_MASK = {PC_W{1'b1}};
`endif

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_raw;
    logic [PC_W-1:0] pc_nxt;
    logic [15:0]     instr;
    logic [15:0]     instr_nxt;
    pc_src_e         src;

    assign src = pc_src_e'(bus.pc_src);

    always_comb begin
        pc_raw    = pc + PC_ONE;
        instr_nxt = bus.prog_data;
        case (src)
            SRC_STALL: begin
                pc_raw    = pc;
                instr_nxt = instr;
            end
            SRC_SKIP: begin
                pc_raw    = pc + PC_TWO;
                instr_nxt = NOP_WORD;
            end
            SRC_JMP: begin
                pc_raw    = bus.jmp;
                instr_nxt = NOP_WORD;
            end
            // Offset is relative to the following word; two's-complement add wraps naturally.
            SRC_RJMP: begin
                pc_raw    = pc + PC_ONE + bus.jmp;
                instr_nxt = NOP_WORD;
            end
            SRC_RVEC: begin
                pc_raw    = RST_VEC;
                instr_nxt = NOP_WORD;
            end
            default: begin
                pc_raw    = pc + PC_ONE;
                instr_nxt = bus.prog_data;
            end
        endcase
        pc_nxt = pc_raw & PC_MASK;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            pc    <= RST_VEC & PC_MASK;
            instr <= NOP_WORD;
        end else begin
            pc    <= pc_nxt;
            instr <= instr_nxt;
        end
    end

    assign bus.prog_addr = pc;
    assign bus.cur_instr = instr;

endmodule

// File: tb/tb_avr_fetch_unit.sv
// Bench for avr_fetch_unit: directed vector table from reset, then random pc_src/jmp against a reference model.
module tb_avr_fetch_unit;

    logic CLK;
    logic RST;

    avr_fetch_unit_if #(.PC_W(16)) fif ();

    avr_fetch_unit #(
        .PC_W    (16),
        .RST_VEC (16'h0000),
        .NOP_WORD(16'h0000),
        .PMEM_AW (9)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(fif)
    );

    // Program memory image: word i holds 0x1000+i, read combinationally.
    assign fif.prog_data = 16'h1000 + fif.prog_addr;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

`ifdef AVR_FETCH_PMEM_WRAP_EN
    localparam logic [15:0] MASK = 16'h01FF;
`else
    localparam logic [15:0] MASK = 16'hFFFF;
`endif

    typedef struct {
        logic        rst_n;
        logic [2:0]  src;
        logic [15:0] jmp;
        logic [15:0] exp_addr;
        logic [15:0] exp_instr;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic r, input logic [2:0] s, input logic [15:0] j,
                       input logic [15:0] a, input logic [15:0] i);
        vec_t v;
        v.rst_n = r; v.src = s; v.jmp = j; v.exp_addr = a; v.exp_instr = i;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, let the rising edge update, sample 1 time unit later.
    task automatic apply(input logic r, input logic [2:0] s, input logic [15:0] j);
        @(negedge CLK);
        RST        = r;
        fif.pc_src = s;
        fif.jmp    = j;
        @(posedge CLK);
        #1;
        // Inputs wiggle between edges; only the edge-time values may matter.
        fif.pc_src = 3'($urandom);
        fif.jmp    = 16'($urandom);
    endtask

    // Reference model state.
    logic [15:0] m_pc;
    logic [15:0] m_instr;

    task automatic model_step(input logic r, input logic [2:0] s, input logic [15:0] j);
        logic [15:0] word;
        word = 16'h1000 + m_pc;
        if (!r) begin
            m_pc    = 16'h0000;
            m_instr = 16'h0000;
        end else if (s == 3'b010) begin
            m_pc = m_pc;
        end else if (s == 3'b011) begin
            m_pc    = m_pc + 16'd2;
            m_instr = 16'h0000;
        end else if (s == 3'b100) begin
            m_pc    = j;
            m_instr = 16'h0000;
        end else if (s == 3'b101) begin
            m_pc    = m_pc + 16'd1 + j;
            m_instr = 16'h0000;
        end else if (s == 3'b110) begin
            m_pc    = 16'h0000;
            m_instr = 16'h0000;
        end else begin
            m_pc    = m_pc + 16'd1;
            m_instr = word;
        end
        m_pc = m_pc & MASK;
    endtask

    initial begin
        RST        = 1'b0;
        fif.pc_src = 3'b000;
        fif.jmp    = 16'h0000;

        // rst, src, jmp, expected prog_addr, expected cur_instr
        add(1'b0, 3'b000, 16'h0000, 16'h0000, 16'h0000);
        add(1'b1, 3'b000, 16'h0000, 16'h0001, 16'h1000);
        add(1'b1, 3'b000, 16'h0000, 16'h0002, 16'h1001);
        add(1'b1, 3'b000, 16'h0000, 16'h0003, 16'h1002);
        add(1'b1, 3'b011, 16'h0000, 16'h0005, 16'h0000);
        add(1'b1, 3'b000, 16'h0000, 16'h0006, 16'h1005);
        add(1'b1, 3'b100, 16'h0004, 16'h0004, 16'h0000);
        add(1'b1, 3'b000, 16'h0000, 16'h0005, 16'h1004);
        add(1'b1, 3'b010, 16'h0000, 16'h0005, 16'h1004);
        add(1'b1, 3'b010, 16'h0000, 16'h0005, 16'h1004);
        add(1'b1, 3'b000, 16'h0000, 16'h0006, 16'h1005);
        add(1'b1, 3'b100, 16'h0008, 16'h0008, 16'h0000);
        add(1'b1, 3'b101, 16'h0050, 16'h0059, 16'h0000);
        add(1'b1, 3'b100, 16'h0005, 16'h0005, 16'h0000);
        add(1'b1, 3'b000, 16'h0000, 16'h0006, 16'h1005);
        add(1'b1, 3'b110, 16'h1234, 16'h0000, 16'h0000);
        add(1'b1, 3'b001, 16'h0000, 16'h0001, 16'h1000);
        add(1'b1, 3'b111, 16'h0000, 16'h0002, 16'h1001);
`ifdef AVR_FETCH_PMEM_WRAP_EN
        add(1'b1, 3'b101, 16'hFFFC, 16'h01FF, 16'h0000);
        add(1'b1, 3'b000, 16'h0000, 16'h0000, 16'h11FF);
        add(1'b1, 3'b100, 16'h0250, 16'h0050, 16'h0000);
        add(1'b1, 3'b000, 16'h0000, 16'h0051, 16'h1050);
`else
        add(1'b1, 3'b101, 16'hFFFC, 16'hFFFF, 16'h0000);
        add(1'b1, 3'b000, 16'h0000, 16'h0000, 16'h0FFF);
        add(1'b1, 3'b100, 16'hFFFF, 16'hFFFF, 16'h0000);
        add(1'b1, 3'b000, 16'h0000, 16'h0000, 16'h0FFF);
`endif
        // Reset during a stall and during a jump discards the request.
        add(1'b1, 3'b100, 16'h0020, 16'h0020, 16'h0000);
        add(1'b1, 3'b000, 16'h0000, 16'h0021, 16'h1020);
        add(1'b0, 3'b010, 16'h0000, 16'h0000, 16'h0000);
        add(1'b1, 3'b000, 16'h0000, 16'h0001, 16'h1000);
        add(1'b1, 3'b000, 16'h0000, 16'h0002, 16'h1001);
        add(1'b0, 3'b100, 16'h0030, 16'h0000, 16'h0000);
        add(1'b1, 3'b000, 16'h0000, 16'h0001, 16'h1000);

        foreach (vecs[k]) begin
            apply(vecs[k].rst_n, vecs[k].src, vecs[k].jmp);
            check($sformatf("vec%0d_addr", k), fif.prog_addr, vecs[k].exp_addr);
            check($sformatf("vec%0d_instr", k), fif.cur_instr, vecs[k].exp_instr);
        end

        // Random phase: start from a known reset, then mix all pc_src codes.
        apply(1'b0, 3'b000, 16'h0000);
        m_pc    = 16'h0000;
        m_instr = 16'h0000;
        check("rand_reset_addr", fif.prog_addr, m_pc);
        check("rand_reset_instr", fif.cur_instr, m_instr);
        for (int n = 0; n < 2000; n++) begin
            logic        r;
            logic [2:0]  s;
            logic [15:0] j;
            r = ($urandom_range(0, 31) != 0);
            s = 3'($urandom);
            j = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($signed(8'($urandom)));
            apply(r, s, j);
            model_step(r, s, j);
            check($sformatf("rand%0d_addr", n), fif.prog_addr, m_pc);
            check($sformatf("rand%0d_instr", n), fif.cur_instr, m_instr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
